// File: rtl/imm_extend_pfx_pkg.sv
// Immediate-source encodings and default width for the decode-stage immediate extender.
// Pure declarations: no logic, no latency, no flow control.
package imm_pkg;

  localparam int DATA_W_DEFAULT = 19;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_A    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_C    = 3'd3;
  localparam logic [2:0] IMM_PFX  = 3'd4;

endpackage

// File: rtl/imm_ext_comb.sv
// Format select and sign/zero extension of the Decode immediate; prefix concatenation for format C.
// Combinational, zero latency, no flow control; zero extension only when IMM_ZEXT_EN is defined.
module imm_ext_comb
  import imm_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int IMM_A_W   = 11,
  parameter int IMM_B_LSB = 3,
  parameter int IMM_C_W   = 8,
  parameter int PFX_W     = DATA_W - IMM_C_W
) (
  input  logic [DATA_W-1:0] instr,
  input  logic [2:0]        immsrc,
  input  logic              pfx_pending,
  input  logic [PFX_W-1:0]  pfx_val,
`ifdef IMM_ZEXT_EN
  input  logic              uns,
`endif
  output logic [DATA_W-1:0] imm_ext,
  output logic              pfx_use
);

  logic              zext;
  logic [IMM_A_W-1:0] fld_a;
  logic [IMM_A_W-1:0] fld_b;
  logic [IMM_C_W-1:0] fld_c;
  logic               unused_instr;

`ifdef IMM_ZEXT_EN
  assign zext = uns;
`else
  assign zext = 1'b0;
`endif

  assign fld_a = instr[IMM_A_W-1:0];
  assign fld_b = instr[IMM_B_LSB+IMM_A_W-1:IMM_B_LSB];
  assign fld_c = instr[IMM_C_W-1:0];

  // Upper instruction bits are opcode space, never part of any immediate field.
  assign unused_instr = ^instr;

  assign pfx_use = (immsrc == IMM_C) && pfx_pending;

  always_comb begin
    imm_ext = '0;
    case (immsrc)
      IMM_A:   imm_ext = {{(DATA_W-IMM_A_W){fld_a[IMM_A_W-1] & ~zext}}, fld_a};
      IMM_B:   imm_ext = {{(DATA_W-IMM_A_W){fld_b[IMM_A_W-1] & ~zext}}, fld_b};
      IMM_C: begin
        if (pfx_pending) imm_ext = {pfx_val, fld_c};
        else             imm_ext = {{(DATA_W-IMM_C_W){fld_c[IMM_C_W-1] & ~zext}}, fld_c};
      end
      default: imm_ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_pfx.sv
// Decode immediate extender with PFX upper-bits prefix; registered into Execute, 1-cycle latency.
// stallD holds Execute and prefix state, flushE bubbles Execute, flushD drops the prefix; IMM_ZEXT_EN adds unsD.
module imm_extend_pfx
  import imm_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int IMM_A_W   = 11,
  parameter int IMM_B_LSB = 3,
  parameter int IMM_C_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              flushE,
  input  logic [DATA_W-1:0] instrD,
  input  logic [2:0]        immsrcD,
`ifdef IMM_ZEXT_EN
  input  logic              unsD,
`endif
  output logic [DATA_W-1:0] imm_extE,
  output logic              pfx_usedE,
  output logic              pfx_pending
);

  localparam int PFX_W = DATA_W - IMM_C_W;

  logic [PFX_W-1:0]  pfx_reg;
  logic [DATA_W-1:0] ext_d;
  logic              pfx_use_d;

  imm_ext_comb #(
    .DATA_W    (DATA_W),
    .IMM_A_W   (IMM_A_W),
    .IMM_B_LSB (IMM_B_LSB),
    .IMM_C_W   (IMM_C_W),
    .PFX_W     (PFX_W)
  ) u_ext (
    .instr       (instrD),
    .immsrc      (immsrcD),
    .pfx_pending (pfx_pending),
    .pfx_val     (pfx_reg),
`ifdef IMM_ZEXT_EN
    .uns         (unsD),
`endif
    .imm_ext     (ext_d),
    .pfx_use     (pfx_use_d)
  );

  // flushE outranks stallD so a load-use bubble still reaches Execute.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imm_extE  <= '0;
      pfx_usedE <= 1'b0;
    end else if (flushE) begin
      imm_extE  <= '0;
      pfx_usedE <= 1'b0;
    end else if (!stallD) begin
      imm_extE  <= ext_d;
      pfx_usedE <= pfx_use_d;
    end
  end

  // Any non-PFX instruction leaving Decode consumes or discards the prefix.
  always_ff @(posedge clk) begin
    if (!rst_n || flushD) begin
      pfx_reg     <= '0;
      pfx_pending <= 1'b0;
    end else if (!stallD) begin
      if (immsrcD == IMM_PFX) begin
        pfx_reg     <= instrD[PFX_W-1:0];
        pfx_pending <= 1'b1;
      end else begin
        pfx_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pfx.sv
// Directed-vector bench for imm_extend_pfx: driver queues expected Execute state, negedge monitor compares.
module tb_imm_extend_pfx;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallD, flushD, flushE;
  logic [18:0] instrD;
  logic [2:0]  immsrcD;
  logic        unsD;
  logic [18:0] imm_extE;
  logic        pfx_usedE;
  logic        pfx_pending;

  always #5 clk = ~clk;

  imm_extend_pfx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stallD      (stallD),
    .flushD      (flushD),
    .flushE      (flushE),
    .instrD      (instrD),
    .immsrcD     (immsrcD),
`ifdef IMM_ZEXT_EN
    .unsD        (unsD),
`endif
    .imm_extE    (imm_extE),
    .pfx_usedE   (pfx_usedE),
    .pfx_pending (pfx_pending)
  );

  typedef struct {
    int          cyc;
    int          id;
    logic [18:0] imm;
    logic        used;
    logic        pend;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   vec_id = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares whatever expectation targets the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL vec%0d missed: expected at cycle %0d, now %0d", e.id, e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      if (imm_extE !== e.imm) begin
        failures++;
        $display("FAIL vec%0d imm_extE got=%05h exp=%05h", e.id, imm_extE, e.imm);
      end
      checks++;
      if (pfx_usedE !== e.used) begin
        failures++;
        $display("FAIL vec%0d pfx_usedE got=%b exp=%b", e.id, pfx_usedE, e.used);
      end
      checks++;
      if (pfx_pending !== e.pend) begin
        failures++;
        $display("FAIL vec%0d pfx_pending got=%b exp=%b", e.id, pfx_pending, e.pend);
      end
    end
  end

  // Drive one Decode cycle; expectation is the state just after the next rising edge.
  task automatic step(input logic r, input logic [2:0] src, input logic [18:0] ins,
                      input logic st, input logic fe, input logic fd, input logic un,
                      input logic [18:0] ei, input logic eu, input logic ep);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n   = r;
    immsrcD = src;
    instrD  = ins;
    stallD  = st;
    flushE  = fe;
    flushD  = fd;
    unsD    = un;
    vec_id++;
    x.cyc  = cyc + 1;
    x.id   = vec_id;
    x.imm  = ei;
    x.used = eu;
    x.pend = ep;
    q.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0; stallD = 1'b0; flushD = 1'b0; flushE = 1'b0;
    instrD = '0; immsrcD = IMM_NONE; unsD = 1'b0;

    //     rst src       instr     st fe fd un  exp_imm   used pend
    step(0, IMM_A,    19'h7FFFF, 0, 0, 0, 0, 19'h00000, 0, 0); // reset state
    step(0, IMM_PFX,  19'h00555, 0, 0, 0, 0, 19'h00000, 0, 0);
    step(1, IMM_A,    19'h00400, 0, 0, 0, 0, 19'h7FC00, 0, 0);
    step(1, IMM_B,    19'h03FF8, 0, 0, 0, 0, 19'h7FFFF, 0, 0);
    step(1, IMM_C,    19'h0007F, 0, 0, 0, 0, 19'h0007F, 0, 0);
    step(1, IMM_C,    19'h00080, 0, 0, 0, 0, 19'h7FF80, 0, 0);
    step(1, 3'd5,     19'h7FFFF, 0, 0, 0, 0, 19'h00000, 0, 0); // reserved
    step(1, IMM_NONE, 19'h7FFFF, 0, 0, 0, 0, 19'h00000, 0, 0);
    // basic prefix
    step(1, IMM_PFX,  19'h00555, 0, 0, 0, 0, 19'h00000, 0, 1);
    step(1, IMM_C,    19'h000AA, 0, 0, 0, 0, 19'h555AA, 1, 0);
    // load-use bubble keeps the prefix
    step(1, IMM_PFX,  19'h00555, 0, 0, 0, 0, 19'h00000, 0, 1);
    step(1, IMM_C,    19'h000AA, 1, 1, 0, 0, 19'h00000, 0, 1);
    step(1, IMM_C,    19'h000AA, 0, 0, 0, 0, 19'h555AA, 1, 0);
    // plain stall holds Execute and prefix
    step(1, IMM_PFX,  19'h00555, 0, 0, 0, 0, 19'h00000, 0, 1);
    step(1, IMM_C,    19'h000AA, 1, 0, 0, 0, 19'h00000, 0, 1);
    step(1, IMM_C,    19'h000AA, 0, 0, 0, 0, 19'h555AA, 1, 0);
    step(1, IMM_A,    19'h00001, 0, 0, 0, 0, 19'h00001, 0, 0);
    step(1, IMM_B,    19'h03FF8, 1, 0, 0, 0, 19'h00001, 0, 0);
    // flushD discards
    step(1, IMM_PFX,  19'h00555, 0, 0, 0, 0, 19'h00000, 0, 1);
    step(1, IMM_NONE, 19'h00000, 0, 0, 1, 0, 19'h00000, 0, 0);
    step(1, IMM_C,    19'h00080, 0, 0, 0, 0, 19'h7FF80, 0, 0);
    // intervening A discards
    step(1, IMM_PFX,  19'h00555, 0, 0, 0, 0, 19'h00000, 0, 1);
    step(1, IMM_A,    19'h00001, 0, 0, 0, 0, 19'h00001, 0, 0);
    step(1, IMM_C,    19'h00080, 0, 0, 0, 0, 19'h7FF80, 0, 0);
    // reset mid-operation
    step(1, IMM_PFX,  19'h00555, 0, 0, 0, 0, 19'h00000, 0, 1);
    step(0, IMM_C,    19'h000AA, 0, 0, 0, 0, 19'h00000, 0, 0);
    step(1, IMM_C,    19'h000AA, 0, 0, 0, 0, 19'h7FFAA, 0, 0);
    // back-to-back PFX: last wins, full 11-bit prefix
    step(1, IMM_PFX,  19'h00123, 0, 0, 0, 0, 19'h00000, 0, 1);
    step(1, IMM_PFX,  19'h007FF, 0, 0, 0, 0, 19'h00000, 0, 1);
    step(1, IMM_C,    19'h00001, 0, 0, 0, 0, 19'h7FF01, 1, 0);
    // flushE alone bubbles Execute
    step(1, IMM_A,    19'h00400, 0, 1, 0, 0, 19'h00000, 0, 0);
`ifdef IMM_ZEXT_EN
    step(1, IMM_C,    19'h00080, 0, 0, 0, 1, 19'h00080, 0, 0);
    step(1, IMM_A,    19'h00400, 0, 0, 0, 1, 19'h00400, 0, 0);
    step(1, IMM_B,    19'h03FF8, 0, 0, 0, 1, 19'h007FF, 0, 0);
    step(1, IMM_PFX,  19'h00555, 0, 0, 0, 1, 19'h00000, 0, 1);
    step(1, IMM_C,    19'h000AA, 0, 0, 0, 1, 19'h555AA, 1, 0);
`endif
    step(1, IMM_NONE, 19'h00000, 0, 0, 0, 0, 19'h00000, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
